// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared internal data bus: one oe + one we per transfer cycle.
// Optional turnaround cycle between transfers with different sources: define REG_BUS_TURNAROUND_EN.
module reg_bus_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NSRC = 8,
  parameter int unsigned NDST = 8,
  localparam int unsigned SRC_W = $clog2(NSRC),
  localparam int unsigned DST_W = $clog2(NDST),
  localparam int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SRC_W-1:0]   req_src,
  input  logic [NREQ*DST_W-1:0]   req_dst,
  output logic [NREQ-1:0]         gnt,
  output logic [NSRC-1:0]         oe,
  output logic [NDST-1:0]         we,
  output logic                    err,
  output logic                    busy
);

`ifdef REG_BUS_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d, ptr_next;
  logic [NREQ-1:0]    gnt_d, cand;
  logic [NSRC-1:0]    oe_d;
  logic [NDST-1:0]    we_d;
  logic               err_d, busy_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [SRC_W-1:0]   win_src;
  logic [DST_W-1:0]   win_dst;

  logic               iss;
  logic [PTR_W-1:0]   iss_w;
  logic [SRC_W-1:0]   iss_src;
  logic [DST_W-1:0]   iss_dst;

`ifdef REG_BUS_TURNAROUND_EN
  logic [SRC_W-1:0]   cur_src, cur_src_d;
  logic [PTR_W-1:0]   pend_w, pend_w_d;
  logic [SRC_W-1:0]   pend_src, pend_src_d;
  logic [DST_W-1:0]   pend_dst, pend_dst_d;
`endif

  // Round-robin search from ptr upward with wrap; the requester granted this cycle is masked.
  always_comb begin
    cand    = req & ~gnt;
    found   = 1'b0;
    win     = '0;
    win_src = '0;
    win_dst = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && cand[i] && (i >= 32'(ptr))) begin
        found   = 1'b1;
        win     = PTR_W'(i);
        win_src = req_src[i*SRC_W +: SRC_W];
        win_dst = req_dst[i*DST_W +: DST_W];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && cand[i] && (i < 32'(ptr))) begin
        found   = 1'b1;
        win     = PTR_W'(i);
        win_src = req_src[i*SRC_W +: SRC_W];
        win_dst = req_dst[i*DST_W +: DST_W];
      end
    end
    ptr_next = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = '0;
    oe_d    = '0;
    we_d    = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    iss     = 1'b0;
    iss_w   = win;
    iss_src = win_src;
    iss_dst = win_dst;
`ifdef REG_BUS_TURNAROUND_EN
    cur_src_d  = cur_src;
    pend_w_d   = pend_w;
    pend_src_d = pend_src;
    pend_dst_d = pend_dst;
`endif

    unique case (state)
      IDLE: begin
        if (found) begin
          iss     = 1'b1;
          ptr_d   = ptr_next;
          state_d = XFER;
        end
      end
      XFER: begin
        if (found) begin
          ptr_d = ptr_next;
`ifdef REG_BUS_TURNAROUND_EN
          if (win_src != cur_src) begin
            state_d    = TURN;
            busy_d     = 1'b1;
            pend_w_d   = win;
            pend_src_d = win_src;
            pend_dst_d = win_dst;
          end else begin
            iss     = 1'b1;
            state_d = XFER;
          end
`else
          iss     = 1'b1;
          state_d = XFER;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef REG_BUS_TURNAROUND_EN
      TURN: begin
        iss     = 1'b1;
        iss_w   = pend_w;
        iss_src = pend_src;
        iss_dst = pend_dst;
        state_d = XFER;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Out-of-range indices shift the single bit off the top, leaving that enable vector zero.
    if (iss) begin
      gnt_d  = NREQ'(1) << iss_w;
      oe_d   = NSRC'(1) << iss_src;
      we_d   = NDST'(1) << iss_dst;
      err_d  = (32'(iss_src) >= NSRC) || (32'(iss_dst) >= NDST);
      busy_d = 1'b1;
`ifdef REG_BUS_TURNAROUND_EN
      cur_src_d = iss_src;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      oe    <= '0;
      we    <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
`ifdef REG_BUS_TURNAROUND_EN
      cur_src  <= '0;
      pend_w   <= '0;
      pend_src <= '0;
      pend_dst <= '0;
`endif
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      oe    <= oe_d;
      we    <= we_d;
      err   <= err_d;
      busy  <= busy_d;
`ifdef REG_BUS_TURNAROUND_EN
      cur_src  <= cur_src_d;
      pend_w   <= pend_w_d;
      pend_src <= pend_src_d;
      pend_dst <= pend_dst_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus randomized traffic against a transfer-level model.
// Two instances: default geometry (NSRC=8) and NSRC=6 to exercise out-of-range sources.
module tb_reg_bus_arbiter;
`ifdef REG_BUS_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_src, req_dst;
  logic [3:0]  gnt, gnt6;
  logic [7:0]  oe, we, we6;
  logic [5:0]  oe6;
  logic        err, err6, busy, busy6;

  int errors = 0;
  int checks = 0;

  // Model of the transfer in progress (-1 = none), pending turnaround winner and rotation pointer.
  int m_cur, m_turn, m_pend, m_ptr, m_src, m_dst, m_psrc, m_pdst;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NREQ(4), .NSRC(8), .NDST(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src), .req_dst(req_dst),
    .gnt(gnt), .oe(oe), .we(we), .err(err), .busy(busy));

  reg_bus_arbiter #(.NREQ(4), .NSRC(6), .NDST(8)) u_dut6 (
    .clk(clk), .rst(rst), .req(req), .req_src(req_src), .req_dst(req_dst),
    .gnt(gnt6), .oe(oe6), .we(we6), .err(err6), .busy(busy6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input int s, input int d);
    req_src[i*3 +: 3] = 3'(s);
    req_dst[i*3 +: 3] = 3'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req_src = '0;
    req_dst = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_cur = -1; m_turn = 0; m_pend = 0; m_ptr = 0;
    m_src = 0; m_dst = 0; m_psrc = 0; m_pdst = 0;
  endtask

  // One clock of the arbitration rules applied to the inputs present now.
  task automatic model_step();
    int w;
    int s;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_turn != 0) begin
      m_cur = m_pend; m_src = m_psrc; m_dst = m_pdst; m_turn = 0;
      return;
    end
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (w < 0 && req[i] && i != m_cur) w = i;
    end
    if (w < 0) begin
      m_cur = -1;
      return;
    end
    m_ptr = (w + 1) % 4;
    s = 32'(req_src[w*3 +: 3]);
    d = 32'(req_dst[w*3 +: 3]);
    if (TURN_EN && m_cur >= 0 && s != m_src) begin
      m_turn = 1; m_pend = w; m_psrc = s; m_pdst = d; m_cur = -1;
    end else begin
      m_cur = w; m_src = s; m_dst = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_rq(i, 2, i + 4);
    tick();
    checks++;
    if ({gnt, oe, we, err, busy} !== 22'd0) begin
      errors++; $display("FAIL reset_cycle1: got %h want 0", {gnt, oe, we, err, busy});
    end
    tick();
    checks++;
    if ({gnt, oe, we, err, busy} !== 22'd0) begin
      errors++; $display("FAIL reset_cycle2: got %h want 0", {gnt, oe, we, err, busy});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt);
    end
    checks++;
    if ({oe, we, busy} !== {8'h04, 8'h10, 1'b1}) begin
      errors++; $display("FAIL reset_first_xfer: got oe=%h we=%h busy=%b want 04 10 1", oe, we, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_rq(2, 3, 5);
    req = 4'b0100;
    tick();
    checks++;
    if ({gnt, oe, we, err, busy} !== {4'b0100, 8'h08, 8'h20, 1'b0, 1'b1}) begin
      errors++; $display("FAIL single_xfer: got gnt=%b oe=%h we=%h err=%b busy=%b want 0100 08 20 0 1",
                         gnt, oe, we, err, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, oe, we, busy} !== 21'd0) begin
      errors++; $display("FAIL single_idle: got gnt=%b oe=%h we=%h busy=%b want all 0", gnt, oe, we, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 2, i + 4);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_g = 4'(1 << (k % 4));
      checks++;
      if (gnt !== exp_g) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g);
      end
      checks++;
      if ($countones(oe) > 1 || oe !== 8'h04) begin
        errors++; $display("FAIL rr_oe[%0d]: got %h want 04", k, oe);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_rq(0, 7, 2);
    req = 4'b0001;
    tick();
    checks++;
    if ({gnt6, oe6, we6, err6} !== {4'b0001, 6'h00, 8'h04, 1'b1}) begin
      errors++; $display("FAIL oor_nsrc6: got gnt=%b oe=%h we=%h err=%b want 0001 00 04 1", gnt6, oe6, we6, err6);
    end
    checks++;
    if ({gnt, oe, we, err} !== {4'b0001, 8'h80, 8'h04, 1'b0}) begin
      errors++; $display("FAIL oor_nsrc8: got gnt=%b oe=%h we=%h err=%b want 0001 80 04 0", gnt, oe, we, err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_rq(0, 1, 3);
    set_rq(1, 2, 4);
    req = 4'b0011;
    tick();
    checks++;
    if ({gnt, oe, we} !== {4'b0001, 8'h02, 8'h08}) begin
      errors++; $display("FAIL b2b_first: got gnt=%b oe=%h we=%h want 0001 02 08", gnt, oe, we);
    end
    req = 4'b0010;
`ifdef REG_BUS_TURNAROUND_EN
    tick();
    checks++;
    if ({gnt, oe, we, busy} !== {4'b0000, 8'h00, 8'h00, 1'b1}) begin
      errors++; $display("FAIL b2b_turn: got gnt=%b oe=%h we=%h busy=%b want 0 0 0 1", gnt, oe, we, busy);
    end
`endif
    tick();
    checks++;
    if ({gnt, oe, we} !== {4'b0010, 8'h04, 8'h10}) begin
      errors++; $display("FAIL b2b_second: got gnt=%b oe=%h we=%h want 0010 04 10", gnt, oe, we);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
    // Same source on both: never a turnaround gap.
    do_reset();
    set_rq(0, 5, 0);
    set_rq(1, 5, 1);
    req = 4'b0011;
    tick();
    checks++;
    if ({gnt, oe, we} !== {4'b0001, 8'h20, 8'h01}) begin
      errors++; $display("FAIL same_src_first: got gnt=%b oe=%h we=%h want 0001 20 01", gnt, oe, we);
    end
    req = 4'b0010;
    tick();
    checks++;
    if ({gnt, oe, we} !== {4'b0010, 8'h20, 8'h02}) begin
      errors++; $display("FAIL same_src_second: got gnt=%b oe=%h we=%h want 0010 20 02", gnt, oe, we);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 2, i);
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_g0: got %b want 0001", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL midrst_g1: got %b want 0010", gnt);
    end
    rst = 1'b1;
    req = 4'b1101;
    tick();
    checks++;
    if ({gnt, oe, we, err, busy, gnt6, busy6} !== 27'd0) begin
      errors++; $display("FAIL midrst_idle: got gnt=%b oe=%h we=%h err=%b busy=%b want all 0",
                         gnt, oe, we, err, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_after: got %b want 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [21:0] e8;
    logic [19:0] e6;
    int last;
    int cur_g;
    do_reset();
    model_reset();
    last = -1;
    for (int n = 0; n < 600; n++) begin
      tick();
      e8 = '0;
      e6 = '0;
      if (m_cur >= 0) begin
        e8 = {4'(1 << m_cur), 8'(1 << m_src), 8'(1 << m_dst), 1'b0, 1'b1};
        e6 = {4'(1 << m_cur), (m_src < 6) ? 6'(1 << m_src) : 6'd0, 8'(1 << m_dst), m_src >= 6, 1'b1};
      end
      if (m_turn != 0) begin
        e8[0] = 1'b1;
        e6[0] = 1'b1;
      end
      checks++;
      if ({gnt, oe, we, err, busy} !== e8) begin
        errors++; $display("FAIL rand8[%0d]: got %h want %h", n, {gnt, oe, we, err, busy}, e8);
      end
      checks++;
      if ({gnt6, oe6, we6, err6, busy6} !== e6) begin
        errors++; $display("FAIL rand6[%0d]: got %h want %h", n, {gnt6, oe6, we6, err6, busy6}, e6);
      end
      cur_g = m_cur;
      for (int i = 0; i < 4; i++) begin
        if (i == last) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          set_rq(i, int'($urandom_range(7)), int'($urandom_range(7)));
        end
      end
      rst = ($urandom_range(49) == 0);
      model_step();
      last = cur_g;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
